ram_scan_reader: RTL



---
 rtl/ram_scan_reader.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/ram_scan_reader.sv
// Trail-RAM scan reader: sweeps every on-screen cell through the RAM read port and streams (x, y, colour).
// Build option SCAN_SKIP_EMPTY_EN drops colour-000 cells from the stream.
module ram_scan_reader #(
    parameter int X_MAX = 160,
    parameter int Y_MAX = 120,
    parameter int XW    = 8,
    parameter int YW    = 7,
    parameter int CW    = 3
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [XW+YW-1:0]   ram_addr,
    input  logic [CW-1:0]      ram_q,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [XW-1:0]      pix_x,
    output logic [YW-1:0]      pix_y,
    output logic [CW-1:0]      pix_colour
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [XW-1:0] X_LAST = XW'(X_MAX - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(Y_MAX - 1);
    localparam int EW = XW + YW + CW;

    logic [1:0]    state_r;
    logic [XW-1:0] x_cnt_r;
    logic [YW-1:0] y_cnt_r;
    logic          inflight_r;
    logic [XW-1:0] tag_x_r;
    logic [YW-1:0] tag_y_r;
    logic [EW-1:0] fifo0_r;
    logic [EW-1:0] fifo1_r;
    logic [1:0]    fifo_cnt_r;
    logic [EW-1:0] out_r;
    logic          valid_r;
    logic          busy_r;
    logic          done_r;

    logic          hs_s;
    logic          out_free_s;
    logic          land_s;
    logic          issue_s;
    logic          last_cell_s;
    logic          drained_s;
    logic          pop_s;
    logic          direct_s;
    logic          push_s;
    logic [2:0]    occ_s;
    logic [EW-1:0] land_word_s;
    logic [EW-1:0] fifo0_n_s;
    logic [EW-1:0] fifo1_n_s;
    logic [1:0]    fifo_cnt_n_s;
    logic [EW-1:0] out_n_s;
    logic          valid_n_s;

    assign busy      = busy_r;
    assign done      = done_r;
    assign ram_addr  = {x_cnt_r, y_cnt_r};
    assign pix_valid = valid_r;
    assign {pix_x, pix_y, pix_colour} = out_r;

    // Handshake, read credit and landing decisions
    always_comb begin
        hs_s        = valid_r & pix_ready;
        out_free_s  = ~valid_r | pix_ready;
        land_word_s = {tag_x_r, tag_y_r, ram_q};
`ifdef SCAN_SKIP_EMPTY_EN
        land_s      = inflight_r & (ram_q != {CW{1'b0}});
`else
        land_s      = inflight_r;
`endif
        // Output register plus two skid entries give three slots; an in-flight read holds a slot.
        occ_s       = 3'(inflight_r) + 3'(fifo_cnt_r) + 3'(valid_r) - 3'(hs_s);
        issue_s     = (state_r == S_SCAN) && (occ_s < 3'd3);
        last_cell_s = (x_cnt_r == X_LAST) && (y_cnt_r == Y_LAST);
        drained_s   = ~inflight_r && (fifo_cnt_r == 2'd0) && out_free_s;
        pop_s       = out_free_s && (fifo_cnt_r != 2'd0);
        direct_s    = out_free_s && (fifo_cnt_r == 2'd0) && land_s;
        push_s      = land_s && ~direct_s;
    end

    // Skid buffer and output register next state
    always_comb begin
        fifo0_n_s    = fifo0_r;
        fifo1_n_s    = fifo1_r;
        fifo_cnt_n_s = fifo_cnt_r;
        out_n_s      = out_r;
        valid_n_s    = valid_r;
        if (pop_s) begin
            fifo0_n_s    = fifo1_r;
            fifo_cnt_n_s = fifo_cnt_r - 2'd1;
        end else begin
            fifo_cnt_n_s = fifo_cnt_r;
        end
        if (push_s) begin
            if (fifo_cnt_n_s == 2'd0) begin
                fifo0_n_s = land_word_s;
            end else begin
                fifo1_n_s = land_word_s;
            end
            fifo_cnt_n_s = fifo_cnt_n_s + 2'd1;
        end else begin
            fifo_cnt_n_s = fifo_cnt_n_s;
        end
        if (pop_s) begin
            out_n_s   = fifo0_r;
            valid_n_s = 1'b1;
        end else if (direct_s) begin
            out_n_s   = land_word_s;
            valid_n_s = 1'b1;
        end else if (out_free_s) begin
            valid_n_s = 1'b0;
        end else begin
            valid_n_s = valid_r;
        end
    end

    // Control FSM, scan counters and datapath registers
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_r    <= S_IDLE;
            x_cnt_r    <= {XW{1'b0}};
            y_cnt_r    <= {YW{1'b0}};
            inflight_r <= 1'b0;
            tag_x_r    <= {XW{1'b0}};
            tag_y_r    <= {YW{1'b0}};
            fifo0_r    <= {EW{1'b0}};
            fifo1_r    <= {EW{1'b0}};
            fifo_cnt_r <= 2'd0;
            out_r      <= {EW{1'b0}};
            valid_r    <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            fifo0_r    <= fifo0_n_s;
            fifo1_r    <= fifo1_n_s;
            fifo_cnt_r <= fifo_cnt_n_s;
            out_r      <= out_n_s;
            valid_r    <= valid_n_s;
            inflight_r <= issue_s;
            done_r     <= 1'b0;
            if (issue_s) begin
                tag_x_r <= x_cnt_r;
                tag_y_r <= y_cnt_r;
            end
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        state_r <= S_SCAN;
                        busy_r  <= 1'b1;
                    end
                end
                S_SCAN: begin
                    // Counters return to 0 after the last cell so the address never leaves the screen.
                    if (issue_s) begin
                        if (last_cell_s) begin
                            x_cnt_r <= {XW{1'b0}};
                            y_cnt_r <= {YW{1'b0}};
                            state_r <= S_DRAIN;
                        end else if (x_cnt_r == X_LAST) begin
                            x_cnt_r <= {XW{1'b0}};
                            y_cnt_r <= y_cnt_r + {{(YW-1){1'b0}}, 1'b1};
                        end else begin
                            x_cnt_r <= x_cnt_r + {{(XW-1){1'b0}}, 1'b1};
                        end
                    end
                end
                S_DRAIN: begin
                    if (drained_s) begin
                        state_r <= S_DONE;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule
